mw_writeback: RTL and testbench

- W-stage datapath of the 5-stage MIPS pipeline: M/W pipeline register, write-back data mux, and the general register file (GRF) with internal W-to-D bypass.
- Captures M-stage results every cycle and presents `instr_w` to the W-stage controller.
- Consumes the controller's decoded `w_rfdst`, `rfwr` and `m2sel`.
- Serves D-stage register reads.

---
 rtl/mw_writeback_pkg.sv | 10 +
 rtl/mw_writeback_grf.sv | 64 ++++++
 rtl/mw_writeback.sv | 74 +++++++
 tb/tb_mw_writeback.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mw_writeback_pkg.sv
// Shared constants for the W stage: write-back select encodings, reset PC and the nop word.
package mw_writeback_pkg;

    localparam logic [1:0]  M2SEL_ALU    = 2'b00;
    localparam logic [1:0]  M2SEL_DM     = 2'b01;
    localparam logic [1:0]  M2SEL_PC8    = 2'b10;
    localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
    localparam logic [31:0] NOP          = 32'h0;

endpackage

// File: rtl/mw_writeback_grf.sv
// General register file: 32x32 storage, $0 hardwired to zero, W-to-D bypass on both read ports.
// Optional macro GRF_TRACE_EN prints one simulation line per retiring register write.
module grf
    import mw_writeback_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_pc,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [31:0] r_regs [32];
    logic        w_wr;

    // A write to $0 is neither stored nor bypassed.
    assign w_wr = i_we && (i_waddr != 5'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rd1 = r_regs[i_ra1];
        if (i_ra1 == 5'd0) begin
            o_rd1 = '0;
        end else if (w_wr && (i_ra1 == i_waddr)) begin
            o_rd1 = i_wdata;
        end
    end

    always_comb begin
        o_rd2 = r_regs[i_ra2];
        if (i_ra2 == 5'd0) begin
            o_rd2 = '0;
        end else if (w_wr && (i_ra2 == i_waddr)) begin
            o_rd2 = i_wdata;
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_wr) begin
            $display("@%h: $%d <= %h", i_pc, i_waddr, i_wdata);
        end
    end
`else
    // The PC only feeds the trace print.
    logic w_unused_pc;
    assign w_unused_pc = ^i_pc;
`endif

endmodule

// File: rtl/mw_writeback.sv
// W stage: M/W pipeline register, write-back data mux and the register file.
// Build with GRF_TRACE_EN defined to get a simulation trace of register writes.
module mw_writeback
    import mw_writeback_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_VAL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_m,
    input  logic [31:0] pc_m,
    input  logic [31:0] alu_m,
    input  logic [31:0] dmrd_m,
    output logic [31:0] instr_w,
    output logic [31:0] pc_w,
    input  logic [4:0]  w_rfdst,
    input  logic        rfwr,
    input  logic [1:0]  m2sel,
    output logic [31:0] wd_w,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_alu;
    logic [31:0] r_dmrd;
    logic [31:0] w_wd;

    // No stall path: the register loads every cycle, reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= NOP;
            r_pc    <= PC_RESET;
            r_alu   <= '0;
            r_dmrd  <= '0;
        end else begin
            r_instr <= instr_m;
            r_pc    <= pc_m;
            r_alu   <= alu_m;
            r_dmrd  <= dmrd_m;
        end
    end

    always_comb begin
        w_wd = '0;
        case (m2sel)
            M2SEL_ALU: w_wd = r_alu;
            M2SEL_DM:  w_wd = r_dmrd;
            M2SEL_PC8: w_wd = r_pc + 32'd8;
            default:   w_wd = '0;
        endcase
    end

    assign instr_w = r_instr;
    assign pc_w    = r_pc;
    assign wd_w    = w_wd;

    grf u_grf (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (rfwr),
        .i_waddr (w_rfdst),
        .i_wdata (w_wd),
        .i_pc    (r_pc),
        .i_ra1   (ra1),
        .i_ra2   (ra2),
        .o_rd1   (rd1),
        .o_rd2   (rd2)
    );

endmodule

// File: tb/tb_mw_writeback.sv
// Bench for mw_writeback: directed scenarios plus a randomized run against a behavioural model.
module tb_mw_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_m = '0, pc_m = '0, alu_m = '0, dmrd_m = '0;
    logic [31:0] instr_w, pc_w, wd_w, rd1, rd2;
    logic [4:0]  w_rfdst = '0, ra1 = '0, ra2 = '0;
    logic        rfwr = 1'b0;
    logic [1:0]  m2sel = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: W-stage contents and architectural register values.
    logic [31:0] m_instr, m_pc, m_alu, m_dmrd;
    logic [31:0] m_rf [32];

    always #5 clk = ~clk;

    mw_writeback dut (
        .clk(clk), .reset(reset),
        .instr_m(instr_m), .pc_m(pc_m), .alu_m(alu_m), .dmrd_m(dmrd_m),
        .instr_w(instr_w), .pc_w(pc_w),
        .w_rfdst(w_rfdst), .rfwr(rfwr), .m2sel(m2sel), .wd_w(wd_w),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
    );

    function automatic logic [31:0] exp_wd(input logic [1:0] sel);
        case (sel)
            2'd0:    return m_alu;
            2'd1:    return m_dmrd;
            2'd2:    return m_pc + 32'd8;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (rfwr && w_rfdst != 5'd0 && ra == w_rfdst) return exp_wd(m2sel);
        return m_rf[ra];
    endfunction

    // Commit the model for the coming edge, advance one cycle, settle mid-cycle.
    task automatic tick();
        if (reset) begin
            m_instr = 32'h0; m_pc = 32'h0000_3000; m_alu = 32'h0; m_dmrd = 32'h0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        end else begin
            if (rfwr && w_rfdst != 5'd0) m_rf[w_rfdst] = exp_wd(m2sel);
            m_instr = instr_m; m_pc = pc_m; m_alu = alu_m; m_dmrd = dmrd_m;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_m = 32'h3010; instr_m = $urandom; alu_m = $urandom; dmrd_m = $urandom;
        rfwr = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if (pc_w !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc_w, 32'h3000); end
        n_tests++;
        if (instr_w !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp %h", instr_w, 32'h0); end
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            n_tests++;
            if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 ra=%0d got %h exp 0", i, rd1); end
            n_tests++;
            if (rd2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2 ra=%0d got %h exp 0", 31 - i, rd2); end
        end
    endtask

    task automatic test_alu_wb();
        alu_m = 32'h1234_5678; pc_m = 32'h3000; instr_m = 32'h0100_0000; rfwr = 1'b0;
        tick();
        rfwr = 1'b1; w_rfdst = 5'd8; m2sel = 2'b00; ra1 = 5'd8; alu_m = 32'h5555_0000;
        #1;
        n_tests++;
        if (wd_w !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_wd got %h exp %h", wd_w, 32'h1234_5678); end
        n_tests++;
        if (rd1 !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_bypass got %h exp %h", rd1, 32'h1234_5678); end
        n_tests++;
        if (instr_w !== 32'h0100_0000) begin n_fail++; $display("FAIL alu_instr_w got %h exp %h", instr_w, 32'h0100_0000); end
        tick();
        rfwr = 1'b0;
        #1;
        n_tests++;
        if (rd1 !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_array got %h exp %h", rd1, 32'h1234_5678); end
    endtask

    task automatic test_load_link();
        dmrd_m = 32'hDEAD_BEEF; pc_m = 32'h3008;
        tick();
        rfwr = 1'b1; w_rfdst = 5'd9; m2sel = 2'b01; pc_m = 32'h3004;
        tick();
        w_rfdst = 5'd31; m2sel = 2'b10;
        #1;
        n_tests++;
        if (wd_w !== 32'h300C) begin n_fail++; $display("FAIL link_wd got %h exp %h", wd_w, 32'h300C); end
        pc_m = 32'hFFFF_FFFC;
        tick();
        rfwr = 1'b0; ra1 = 5'd9; ra2 = 5'd31;
        #1;
        n_tests++;
        if (rd1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_r9 got %h exp %h", rd1, 32'hDEAD_BEEF); end
        n_tests++;
        if (rd2 !== 32'h300C) begin n_fail++; $display("FAIL link_r31 got %h exp %h", rd2, 32'h300C); end
        n_tests++;
        if (wd_w !== 32'h4) begin n_fail++; $display("FAIL pc8_wrap got %h exp %h", wd_w, 32'h4); end
        m2sel = 2'b11;
        #1;
        n_tests++;
        if (wd_w !== 32'h0) begin n_fail++; $display("FAIL sel11_zero got %h exp 0", wd_w); end
    endtask

    task automatic test_zero_guard();
        alu_m = 32'hFFFF_FFFF;
        tick();
        rfwr = 1'b1; w_rfdst = 5'd0; m2sel = 2'b00; ra1 = 5'd0; ra2 = 5'd0;
        #1;
        n_tests++;
        if (wd_w !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL zero_wd got %h exp %h", wd_w, 32'hFFFF_FFFF); end
        n_tests++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL zero_same_cycle got %h exp 0", rd1); end
        tick();
        rfwr = 1'b0;
        #1;
        n_tests++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL zero_next_cycle got %h exp 0", rd1); end
    endtask

    task automatic test_reset_during_write();
        alu_m = 32'hAAAA_5555; pc_m = 32'h3040;
        tick();
        rfwr = 1'b1; w_rfdst = 5'd5; m2sel = 2'b00; ra1 = 5'd5; reset = 1'b1;
        #1;
        n_tests++;
        if (rd1 !== 32'hAAAA_5555) begin n_fail++; $display("FAIL rstwr_bypass got %h exp %h", rd1, 32'hAAAA_5555); end
        tick();
        reset = 1'b0; rfwr = 1'b0;
        #1;
        n_tests++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL rstwr_r5 got %h exp 0", rd1); end
        n_tests++;
        if (pc_w !== 32'h3000) begin n_fail++; $display("FAIL rstwr_pc got %h exp %h", pc_w, 32'h3000); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            reset   = ($urandom_range(0, 49) == 0);
            instr_m = $urandom; pc_m = $urandom; alu_m = $urandom; dmrd_m = $urandom;
            rfwr    = $urandom_range(0, 1);
            w_rfdst = 5'($urandom_range(0, 31));
            m2sel   = 2'($urandom_range(0, 3));
            ra1     = $urandom_range(0, 2) == 0 ? w_rfdst : 5'($urandom_range(0, 31));
            ra2     = $urandom_range(0, 3) == 0 ? ra1 : 5'($urandom_range(0, 31));
            #1;
            n_tests++;
            if (wd_w !== exp_wd(m2sel)) begin n_fail++; $display("FAIL rand_wd c=%0d got %h exp %h", c, wd_w, exp_wd(m2sel)); end
            n_tests++;
            if (rd1 !== exp_rd(ra1)) begin n_fail++; $display("FAIL rand_rd1 c=%0d ra=%0d got %h exp %h", c, ra1, rd1, exp_rd(ra1)); end
            n_tests++;
            if (rd2 !== exp_rd(ra2)) begin n_fail++; $display("FAIL rand_rd2 c=%0d ra=%0d got %h exp %h", c, ra2, rd2, exp_rd(ra2)); end
            n_tests++;
            if (pc_w !== m_pc || instr_w !== m_instr) begin
                n_fail++; $display("FAIL rand_wreg c=%0d pc %h/%h instr %h/%h", c, pc_w, m_pc, instr_w, m_instr);
            end
            tick();
        end
        reset = 1'b0; rfwr = 1'b0;
        // Sweep the whole file against the model after the random traffic.
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            #1;
            n_tests++;
            if (rd1 !== exp_rd(ra1)) begin n_fail++; $display("FAIL sweep ra=%0d got %h exp %h", i, rd1, exp_rd(ra1)); end
        end
    endtask

    initial begin
        @(posedge clk);
        #2;
        test_reset();
        test_alu_wb();
        test_load_link();
        test_zero_guard();
        test_reset_during_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
